// File: rtl/ga_host.sv
// ga_host: host-side initiator for the fixed-point geometry accelerator bus.
// Serialises 4x4 Q16.16 operands onto the accelerator port one row per beat,
// and gathers column-ordered result beats back into a row-major 4x4 result.
// Optional feature: define GA_HOST_AUTO_READ_EN to follow every VRT load with
// an automatic result read and response.
module ga_host #(
  parameter int unsigned IDLE_ADDR     = 455,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [0:15][31:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [0:15][31:0] rsp_data,
  output logic [31:0]       ga_addr,
  output logic [0:3][31:0]  ga_wdata,
  input  logic [0:3][31:0]  ga_rdata,
  input  logic              ga_rdy
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [ADDR_W-1:0] ADDR_IDLE   = ADDR_W'(IDLE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MATRIX = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_RSLT   = ADDR_W'(2);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic [1:0] OP_MATRIX = 2'd0;
  localparam logic [1:0] OP_VRT    = 2'd1;
  localparam logic [1:0] OP_RSLT   = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_SYNC,
    S_BEAT1,
    S_BEAT2,
    S_BEAT3,
    S_TAIL,
    S_SETTLE,
    S_RADDR,
    S_CAP0,
    S_CAP1,
    S_CAP2,
    S_CAP3,
    S_RSP
  } state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [0:15][31:0]  mat_q;
  logic               sync_rep;
  logic [CNT_W-1:0]   settle_cnt;

  // Sequencer: every output is loaded on the edge that enters the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= OP_MATRIX;
      mat_q      <= '0;
      sync_rep   <= 1'b0;
      settle_cnt <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      ga_addr    <= ADDR_IDLE;
      ga_wdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            mat_q <= cmd_data;
            if (cmd_op == OP_MATRIX || cmd_op == OP_VRT) begin
              state     <= S_ADDR;
              cmd_ready <= 1'b0;
              ga_addr   <= ADDR_W'(cmd_op);
              ga_wdata  <= '0;
            end else if (cmd_op == OP_RSLT) begin
              state     <= S_RADDR;
              cmd_ready <= 1'b0;
              ga_addr   <= ADDR_RSLT;
            end
            // reserved op: accepted and dropped, stay idle
          end
        end

        S_ADDR: begin
          state    <= S_SYNC;
          sync_rep <= 1'b0;
          ga_wdata <= {mat_q[0], mat_q[1], mat_q[2], mat_q[3]};
        end

        // An idle core at the end of the first SYNC cycle gets one more row-0 cycle.
        S_SYNC: begin
          if (ga_rdy && !sync_rep) begin
            sync_rep <= 1'b1;
          end else begin
            state    <= S_BEAT1;
            ga_wdata <= {mat_q[4], mat_q[5], mat_q[6], mat_q[7]};
          end
        end

        S_BEAT1: begin
          state    <= S_BEAT2;
          ga_wdata <= {mat_q[8], mat_q[9], mat_q[10], mat_q[11]};
        end

        // VRT releases the address already during its last row.
        S_BEAT2: begin
          state    <= S_BEAT3;
          ga_wdata <= {mat_q[12], mat_q[13], mat_q[14], mat_q[15]};
          if (op_q == OP_VRT) ga_addr <= ADDR_IDLE;
        end

        S_BEAT3: begin
          ga_wdata <= '0;
          if (op_q == OP_MATRIX) begin
            state   <= S_TAIL;
            ga_addr <= ADDR_MATRIX;
          end else begin
            state      <= S_SETTLE;
            ga_addr    <= ADDR_IDLE;
            settle_cnt <= '0;
          end
        end

        S_TAIL: begin
          state      <= S_SETTLE;
          ga_addr    <= ADDR_IDLE;
          settle_cnt <= '0;
        end

        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
`ifdef GA_HOST_AUTO_READ_EN
            if (op_q == OP_VRT) begin
              state   <= S_RADDR;
              ga_addr <= ADDR_RSLT;
            end else begin
              state     <= S_IDLE;
              cmd_ready <= 1'b1;
            end
`else
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
`endif
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end

        S_RADDR: begin
          state <= S_CAP0;
        end

        // Column c of the result lands in rsp_data[4r + c] for each row r.
        S_CAP0: begin
          state        <= S_CAP1;
          rsp_data[0]  <= ga_rdata[0];
          rsp_data[4]  <= ga_rdata[1];
          rsp_data[8]  <= ga_rdata[2];
          rsp_data[12] <= ga_rdata[3];
        end

        S_CAP1: begin
          state        <= S_CAP2;
          rsp_data[1]  <= ga_rdata[0];
          rsp_data[5]  <= ga_rdata[1];
          rsp_data[9]  <= ga_rdata[2];
          rsp_data[13] <= ga_rdata[3];
        end

        S_CAP2: begin
          state        <= S_CAP3;
          rsp_data[2]  <= ga_rdata[0];
          rsp_data[6]  <= ga_rdata[1];
          rsp_data[10] <= ga_rdata[2];
          rsp_data[14] <= ga_rdata[3];
        end

        S_CAP3: begin
          state        <= S_RSP;
          rsp_data[3]  <= ga_rdata[0];
          rsp_data[7]  <= ga_rdata[1];
          rsp_data[11] <= ga_rdata[2];
          rsp_data[15] <= ga_rdata[3];
          ga_addr      <= ADDR_IDLE;
          rsp_valid    <= 1'b1;
        end

        S_RSP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          ga_addr   <= ADDR_IDLE;
          ga_wdata  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ga_host.sv
// Directed self-checking bench for ga_host.
module tb_ga_host;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [0:15][31:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [0:15][31:0] rsp_data;
  logic [31:0]       ga_addr;
  logic [0:3][31:0]  ga_wdata;
  logic [0:3][31:0]  ga_rdata;
  logic              ga_rdy;

  int checks = 0;
  int errors = 0;

  ga_host #(.IDLE_ADDR(455), .SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ga_addr   (ga_addr),
    .ga_wdata  (ga_wdata),
    .ga_rdata  (ga_rdata),
    .ga_rdy    (ga_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accelerator read model: one cycle after addr 2 appears, column c is driven
  // on the c-th following cycle as {0x100+c, 0x200+c, 0x300+c, 0x400+c}.
  logic [2:0] a2_cnt;
  always @(posedge clk) begin
    if (rst || ga_addr != 32'd2) a2_cnt <= 3'd0;
    else if (a2_cnt != 3'd7)     a2_cnt <= a2_cnt + 3'd1;
  end

  always_comb begin
    ga_rdata = '0;
    if (a2_cnt >= 3'd1 && a2_cnt <= 3'd4) begin
      for (int r = 0; r < 4; r++)
        ga_rdata[2'(r)] = 32'((r + 1) << 8) + 32'(a2_cnt) - 32'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command; returns after the accept edge (cycle 1 of the transaction).
  task automatic issue(input logic [1:0] op, input logic [0:15][31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'd3;
    cmd_data  = {16{32'hDEAD_BEEF}};
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    ga_rdy    = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    checks++; if (ga_addr !== 32'd455) begin errors++; $display("FAIL reset_ga_addr got %0d want 455", ga_addr); end
    checks++; if (ga_wdata !== '0) begin errors++; $display("FAIL reset_ga_wdata got %h want 0", ga_wdata); end
  endtask

  task automatic test_matrix();
    logic [0:15][31:0] m;
    logic [0:3][31:0]  r0, r1, r2, r3, z;
    logic [31:0]       ea [1:10];
    logic [0:3][31:0]  ew [1:10];
    logic              er [1:10];
    m = '0;
    m[0] = 32'h0001_0000; m[5] = 32'h0001_0000; m[10] = 32'h0001_0000; m[15] = 32'h0001_0000;
    m[3] = 32'h0001_0000; m[7] = 32'h0002_0000; m[11] = 32'h0003_0000;
    r0 = {32'h0001_0000, 32'h0, 32'h0, 32'h0001_0000};
    r1 = {32'h0, 32'h0001_0000, 32'h0, 32'h0002_0000};
    r2 = {32'h0, 32'h0, 32'h0001_0000, 32'h0003_0000};
    r3 = {32'h0, 32'h0, 32'h0, 32'h0001_0000};
    z  = '0;
    ea = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd455, 32'd455, 32'd455};
    ew = '{z, r0, r0, r1, r2, r3, z, z, z, z};
    er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ga_rdy = 1'b1;
    issue(2'd0, m);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) step();
      checks++; if (ga_addr !== ea[k]) begin errors++; $display("FAIL matrix_addr k=%0d got %0d want %0d", k, ga_addr, ea[k]); end
      checks++; if (ga_wdata !== ew[k]) begin errors++; $display("FAIL matrix_wdata k=%0d got %h want %h", k, ga_wdata, ew[k]); end
      checks++; if (cmd_ready !== er[k]) begin errors++; $display("FAIL matrix_cmd_ready k=%0d got %b want %b", k, cmd_ready, er[k]); end
    end
    ga_rdy = 1'b0;
  endtask

  task automatic test_vrt();
    logic [0:15][31:0] m;
    logic [0:3][31:0]  r0, r1, r2, r3, z;
    logic [31:0]       ea [1:8];
    logic [0:3][31:0]  ew [1:8];
    logic              er [1:8];
    m = '0;
    m[0] = 32'h0001_0000; m[4] = 32'h0002_0000; m[8] = 32'h0003_0000; m[12] = 32'h0001_0000;
    r0 = {32'h0001_0000, 32'h0, 32'h0, 32'h0};
    r1 = {32'h0002_0000, 32'h0, 32'h0, 32'h0};
    r2 = {32'h0003_0000, 32'h0, 32'h0, 32'h0};
    r3 = {32'h0001_0000, 32'h0, 32'h0, 32'h0};
    z  = '0;
    ea = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd455, 32'd455, 32'd455, 32'd455};
    ew = '{z, r0, r1, r2, r3, z, z, z};
    er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef GA_HOST_AUTO_READ_EN
    ea[8] = 32'd2;
    er[8] = 1'b0;
`endif
    ga_rdy = 1'b0;
    issue(2'd1, m);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) step();
      checks++; if (ga_addr !== ea[k]) begin errors++; $display("FAIL vrt_addr k=%0d got %0d want %0d", k, ga_addr, ea[k]); end
      checks++; if (ga_wdata !== ew[k]) begin errors++; $display("FAIL vrt_wdata k=%0d got %h want %h", k, ga_wdata, ew[k]); end
      checks++; if (cmd_ready !== er[k]) begin errors++; $display("FAIL vrt_cmd_ready k=%0d got %b want %b", k, cmd_ready, er[k]); end
    end
`ifdef GA_HOST_AUTO_READ_EN
    begin
      int waited;
      waited = 0;
      while (rsp_valid !== 1'b1 && waited < 20) begin
        step();
        waited++;
      end
      checks++; if (waited !== 5) begin errors++; $display("FAIL auto_rsp_latency got %0d want 5", waited); end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          checks++;
          if (rsp_data[4'(4 * r + c)] !== 32'(((r + 1) << 8) + c)) begin
            errors++;
            $display("FAIL auto_rsp_data idx=%0d got %h want %h", 4 * r + c, rsp_data[4'(4 * r + c)], 32'(((r + 1) << 8) + c));
          end
        end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL auto_cmd_ready got %b want 1", cmd_ready); end
    end
`endif
  endtask

  task automatic test_rslt_hold();
    logic [0:15][31:0] exp_rsp;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_rsp[4'(4 * r + c)] = 32'(((r + 1) << 8) + c);
    rsp_ready = 1'b0;
    issue(2'd2, {16{32'h1234_5678}});
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) step();
      if (k < 6) begin
        checks++; if (ga_addr !== 32'd2) begin errors++; $display("FAIL rslt_addr k=%0d got %0d want 2", k, ga_addr); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rslt_early_valid k=%0d got %b want 0", k, rsp_valid); end
      end
    end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rslt_valid_k6 got %b want 1", rsp_valid); end
    checks++; if (ga_addr !== 32'd455) begin errors++; $display("FAIL rslt_addr_rsp got %0d want 455", ga_addr); end
    checks++; if (rsp_data !== exp_rsp) begin errors++; $display("FAIL rslt_data got %h want %h", rsp_data, exp_rsp); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid i=%0d got %b want 1", i, rsp_valid); end
      checks++; if (rsp_data !== exp_rsp) begin errors++; $display("FAIL hold_data i=%0d got %h want %h", i, rsp_data, exp_rsp); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL hold_cmd_ready i=%0d got %b want 0", i, cmd_ready); end
      checks++; if (ga_addr !== 32'd455) begin errors++; $display("FAIL hold_addr i=%0d got %0d want 455", i, ga_addr); end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL exit_valid got %b want 0", rsp_valid); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL exit_cmd_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_reset_mid();
    logic [0:15][31:0] m;
    for (int i = 0; i < 16; i++) m[4'(i)] = 32'hA000_0000 + 32'(i);
    ga_rdy = 1'b0;
    issue(2'd0, m);
    repeat (3) step();
    checks++;
    if (ga_wdata !== {32'hA000_0008, 32'hA000_0009, 32'hA000_000A, 32'hA000_000B}) begin
      errors++; $display("FAIL mid_beat2_row got %h want a0000008a0000009a000000aa000000b", ga_wdata);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL mid_rsp_data got %h want 0", rsp_data); end
    checks++; if (ga_addr !== 32'd455) begin errors++; $display("FAIL mid_ga_addr got %0d want 455", ga_addr); end
    checks++; if (ga_wdata !== '0) begin errors++; $display("FAIL mid_ga_wdata got %h want 0", ga_wdata); end
  endtask

  task automatic test_op3();
    issue(2'd3, {16{32'h5555_AAAA}});
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) step();
      checks++; if (ga_addr !== 32'd455) begin errors++; $display("FAIL op3_addr k=%0d got %0d want 455", k, ga_addr); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL op3_rsp_valid k=%0d got %b want 0", k, rsp_valid); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL op3_cmd_ready k=%0d got %b want 1", k, cmd_ready); end
      checks++; if (ga_wdata !== '0) begin errors++; $display("FAIL op3_wdata k=%0d got %h want 0", k, ga_wdata); end
    end
  endtask

  initial begin
    test_reset();
    test_matrix();
    test_vrt();
    test_rslt_hold();
    test_reset_mid();
    test_op3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "timeout");
  end

endmodule
